// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 stream demultiplexer with a one-entry valid/ready output
// register per channel and per-channel delivered-word counters.
module demux_1to4_reg #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    in_sel,
  output logic [N-1:0]  out_a,
  output logic [N-1:0]  out_b,
  output logic [N-1:0]  out_c,
  output logic [N-1:0]  out_d,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [4*CW-1:0] cnt,
  output logic          busy
);

  logic [N-1:0]  data_q [4];
  logic [CW-1:0] cnt_q  [4];
  logic [3:0]    valid_q;
  logic          accept;
  logic [3:0]    load;
  logic [3:0]    deliver;

  // Ready only looks at the addressed channel, so a stalled lane blocks only its own words.
  always_comb begin
    in_ready     = ~valid_q[in_sel] | out_ready[in_sel];
    accept       = in_valid & in_ready;
    load         = '0;
    load[in_sel] = accept;
    deliver      = valid_q & out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (load[k]) data_q[k] <= in_data;
        valid_q[k] <= load[k] | (valid_q[k] & ~out_ready[k]);
        if (deliver[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < 4; k++) cnt[k*CW +: CW] = cnt_q[k];
  end

  assign out_a     = data_q[0];
  assign out_b     = data_q[1];
  assign out_c     = data_q[2];
  assign out_d     = data_q[3];
  assign out_valid = valid_q;
  assign busy      = |valid_q;

endmodule
